// File: rtl/fet_tri_sweeper_pkg.sv
// Shared definitions for the tri-state pin sweeper: FSM states, drive (trit)
// codes, observation codes and small helpers used by the top and its cells.
package fet_tri_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Drive code per pin: released, drive low, drive high (code 3 is never produced)
    localparam logic [1:0] TRIT_Z = 2'd0;
    localparam logic [1:0] TRIT_0 = 2'd1;
    localparam logic [1:0] TRIT_1 = 2'd2;

    // Captured resolved level per pin
    localparam logic [1:0] OBS_0 = 2'b00;
    localparam logic [1:0] OBS_1 = 2'b01;
    localparam logic [1:0] OBS_Z = 2'b10;
    localparam logic [1:0] OBS_X = 2'b11;

    // Number of vectors in a full sweep of n pins
    function automatic int pow3(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 3;
        end
        return r;
    endfunction

    // Classify one pin's resolved level. A pin that reads back anything other
    // than what we are driving is in contention with an external driver and is
    // reported as x, so opposing drives show up even when the simulator
    // collapses the net to a plain 0/1.
    function automatic logic [1:0] resolvePin(input logic       pinVal,
                                              input logic       pinIsZ,
                                              input logic [1:0] trit,
                                              input logic       driving);
        if (driving && (trit == TRIT_0) && (pinVal !== 1'b0)) return OBS_X;
        if (driving && (trit == TRIT_1) && (pinVal !== 1'b1)) return OBS_X;
        if (pinIsZ)                                          return OBS_Z;
        if (pinVal === 1'b0)                                 return OBS_0;
        if (pinVal === 1'b1)                                 return OBS_1;
        return OBS_X;
    endfunction

endpackage

// File: rtl/fet_tri_sweeper_trit_cell.sv
// One base-3 digit of the sweep counter. Counts z -> 0 -> 1 -> z on each
// increment and raises carry when stepping out of the top digit value.
module fet_tri_sweeper_trit_cell
    import fet_tri_sweeper_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_inc,
    output logic [1:0] o_trit,
    output logic       o_carry
);

    logic [1:0] r_trit;

    // Digit register: clear wins over increment, wraps from drive-high back to released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trit <= TRIT_Z;
        end else if (i_clear) begin
            r_trit <= TRIT_Z;
        end else if (i_inc) begin
            r_trit <= (r_trit == TRIT_1) ? TRIT_Z : (r_trit + 2'd1);
        end
    end

    assign o_trit  = r_trit;
    assign o_carry = i_inc && (r_trit == TRIT_1);

endmodule

// File: rtl/fet_tri_sweeper.sv
// Exhaustive tri-state stimulus generator: walks NPINS pins through every
// {z,0,1} combination, holds each vector DWELL cycles and captures how each
// pin actually resolved. Start/abort/loop control for bench-driven sweeps.
module fet_tri_sweeper
    import fet_tri_sweeper_pkg::*;
#(
    parameter int NPINS  = 3,
    parameter int DWELL  = 2,
    parameter int VIDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 loop,
    input  logic                 abort,
    inout  wire  [NPINS-1:0]     pins,
    output logic                 busy,
    output logic                 done,
    output logic                 sample_stb,
    output logic [VIDX_W-1:0]    vec_idx,
    output logic [2*NPINS-1:0]   trits,
    output logic [2*NPINS-1:0]   obs
);

    localparam int              NVEC       = pow3(NPINS);
    localparam int              DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [VIDX_W-1:0] VIDX_LAST = VIDX_W'(NVEC - 1);

    if ((NPINS < 1) || (DWELL < 1) || ((2 ** VIDX_W) < NVEC)) begin : g_badParams
        $error("fet_tri_sweeper: bad parameters NPINS=%0d DWELL=%0d VIDX_W=%0d",
               NPINS, DWELL, VIDX_W);
    end

    state_t                 r_state;
    logic [DW-1:0]          r_dwell;
    logic [VIDX_W-1:0]      r_vidx;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_stb;
    logic [2*NPINS-1:0]     r_obs;

    logic                   w_driveEn;
    logic                   w_sampleNow;
    logic                   w_lastVec;
    logic                   w_inc;
    logic                   w_clear;
    logic [NPINS:0]         w_carry;
    logic [2*NPINS-1:0]     w_trits;
    logic [NPINS-1:0]       w_pinIsZ;
    logic [2*NPINS-1:0]     w_obsNext;

    // Advance/clear decisions for the digit chain. The last vector only
    // increments (and wraps to all-z) when looping; otherwise it is held so
    // the final trits stay visible after the sweep.
    always_comb begin
        w_driveEn   = (r_state == ST_DRIVE);
        w_sampleNow = w_driveEn && !abort && (r_dwell == DWELL_LAST);
        w_lastVec   = (r_vidx == VIDX_LAST);
        w_inc       = w_sampleNow && !(w_lastVec && !loop);
        w_clear     = (r_state == ST_IDLE) && start && !abort;
    end

    assign w_carry[0] = w_inc;

    for (genvar g = 0; g < NPINS; g++) begin : g_pin
        fet_tri_sweeper_trit_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clear (w_clear),
            .i_inc   (w_carry[g]),
            .o_trit  (w_trits[2*g +: 2]),
            .o_carry (w_carry[g+1])
        );

        assign pins[g] = (w_driveEn && (w_trits[2*g +: 2] == TRIT_0)) ? 1'b0 :
                         (w_driveEn && (w_trits[2*g +: 2] == TRIT_1)) ? 1'b1 : 1'bz;

        assign w_pinIsZ[g] = (pins[g] === 1'bz);

        assign w_obsNext[2*g +: 2] = resolvePin(pins[g], w_pinIsZ[g],
                                                w_trits[2*g +: 2], w_driveEn);
    end

    // Sweep FSM with dwell counter, vector index, observation capture and
    // registered status outputs. done is a single-cycle pulse by default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dwell <= '0;
            r_vidx  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_stb   <= 1'b0;
            r_obs   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_clear) begin
                        r_state <= ST_DRIVE;
                        r_dwell <= '0;
                        r_vidx  <= '0;
                        r_busy  <= 1'b1;
                        r_stb   <= (DWELL == 1);
                    end
                end
                ST_DRIVE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_stb   <= 1'b0;
                    end else if (r_dwell == DWELL_LAST) begin
                        r_obs   <= w_obsNext;
                        r_dwell <= '0;
                        if (w_lastVec && !loop) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_stb   <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_vidx  <= w_carry[NPINS] ? '0 : (r_vidx + VIDX_W'(1));
                            r_done  <= w_lastVec;
                            r_stb   <= (DWELL == 1);
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                        r_stb   <= ((r_dwell + DW'(1)) == DWELL_LAST);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_stb   <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_stb = r_stb;
    assign vec_idx    = r_vidx;
    assign trits      = w_trits;
    assign obs        = r_obs;

endmodule

// File: tb/tb_fet_tri_sweeper.sv
// Bench for fet_tri_sweeper: a one-pin/one-cycle instance driven from a vector
// table, and a three-pin/two-cycle instance exercised by directed sequences
// (one-shot sweep, loop wrap, abort, mid-sweep reset, ignored starts).
module tb_fet_tri_sweeper;

    logic       clk;
    logic       rst_n;

    logic       start1;
    logic       loop1;
    logic       abort1;
    logic       drv1;
    wire  [0:0] pins1;
    logic       busy1;
    logic       done1;
    logic       stb1;
    logic [1:0] vidx1;
    logic [1:0] trits1;
    logic [1:0] obs1;

    logic       start3;
    logic       loop3;
    logic       abort3;
    wire  [2:0] pins3;
    logic       busy3;
    logic       done3;
    logic       stb3;
    logic [4:0] vidx3;
    logic [5:0] trits3;
    logic [5:0] obs3;

    int checks;
    int errors;

    assign pins1[0] = drv1 ? 1'b1 : 1'bz;

    fet_tri_sweeper #(.NPINS(1), .DWELL(1), .VIDX_W(2)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .loop       (loop1),
        .abort      (abort1),
        .pins       (pins1),
        .busy       (busy1),
        .done       (done1),
        .sample_stb (stb1),
        .vec_idx    (vidx1),
        .trits      (trits1),
        .obs        (obs1)
    );

    fet_tri_sweeper #(.NPINS(3), .DWELL(2), .VIDX_W(5)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .loop       (loop3),
        .abort      (abort3),
        .pins       (pins3),
        .busy       (busy3),
        .done       (done3),
        .sample_stb (stb3),
        .vec_idx    (vidx3),
        .trits      (trits3),
        .obs        (obs3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait escapes its bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       startHere;
        logic       drv;
        logic       pinChk;
        logic       expPin;
        logic       expBusy;
        logic       expDone;
        logic       expStb;
        logic [1:0] expTrit;
        logic [1:0] expObs;
    } vec1_t;

    vec1_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the three-pin instance's controls for one clock and sample after the edge
    task automatic applyStimulus(input logic s, input logic a, input logic l);
        start3 = s;
        abort3 = a;
        loop3  = l;
        tick();
        start3 = 1'b0;
        abort3 = 1'b0;
    endtask

    // Step the three-pin instance until vec_idx hits target (optionally on its strobe cycle)
    task automatic waitIdx3(input int target, input logic needStb, input int maxCycles, input logic l);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < maxCycles; k++) begin
            if ((int'(vidx3) == target) && (!needStb || stb3)) begin
                ok = 1'b1;
                break;
            end
            applyStimulus(1'b0, 1'b0, l);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait vec_idx=%0d: got %0d after %0d cycles", target, vidx3, maxCycles);
        end
    endtask

    // Independent base-3 model: digit i of idx in bits [2i+1:2i]
    function automatic logic [5:0] idxToTrits(input int idx);
        logic [5:0] t;
        int         v;
        t = '0;
        v = idx;
        for (int i = 0; i < 3; i++) begin
            t[2*i +: 2] = 2'(v % 3);
            v = v / 3;
        end
        return t;
    endfunction

    initial begin
        int         c;
        int         busyCnt;
        int         stbCnt;
        int         doneCnt;
        bit         finished;
        bit         pulsed;
        logic       s;
        logic [5:0] lastTrits;
        logic [5:0] mt;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start1 = 1'b0; loop1 = 1'b0; abort1 = 1'b0; drv1 = 1'b0;
        start3 = 1'b0; loop3 = 1'b0; abort3 = 1'b0;

        // Reset state of both instances
        #2;
        checkOutput("reset busy3", busy3, 0);
        checkOutput("reset done3", done3, 0);
        checkOutput("reset stb3", stb3, 0);
        checkOutput("reset vec_idx3", vidx3, 0);
        checkOutput("reset trits3", trits3, 0);
        checkOutput("reset obs3", obs3, 0);
        checkOutput("reset busy1", busy1, 0);
        checkOutput("reset obs1", obs1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // One pin, one cycle dwell: floating run, then bench holding the pin high
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'b00};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'b10};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'b00};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'b01};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'b01};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2'b01};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'b01};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'b11};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'b01};

        for (int r = 0; r < 9; r++) begin
            drv1 = tbl[r].drv;
            if (tbl[r].startHere) begin
                tick();
                start1 = 1'b1;
                tick();
                start1 = 1'b0;
            end else begin
                tick();
            end
            checkOutput($sformatf("t1 row%0d busy", r), busy1, tbl[r].expBusy);
            checkOutput($sformatf("t1 row%0d done", r), done1, tbl[r].expDone);
            checkOutput($sformatf("t1 row%0d stb", r), stb1, tbl[r].expStb);
            checkOutput($sformatf("t1 row%0d trits", r), trits1, tbl[r].expTrit);
            checkOutput($sformatf("t1 row%0d vec_idx", r), vidx1, tbl[r].expTrit);
            checkOutput($sformatf("t1 row%0d obs", r), obs1, tbl[r].expObs);
            if (tbl[r].pinChk) begin
                checkOutput($sformatf("t1 row%0d pin", r), pins1[0], tbl[r].expPin);
            end
        end
        drv1 = 1'b0;

        // One-shot three-pin sweep, with a start re-pulse at vector 4 and a start during DONE
        applyStimulus(1'b1, 1'b0, 1'b0);
        c = 0; busyCnt = 0; stbCnt = 0; doneCnt = 0;
        finished = 1'b0; pulsed = 1'b0; lastTrits = '0;
        for (int k = 0; k < 120 && !finished; k++) begin
            s = 1'b0;
            if (busy3) begin
                mt = idxToTrits(c / 2);
                checkOutput($sformatf("t2 c%0d vec_idx", c), vidx3, c / 2);
                checkOutput($sformatf("t2 c%0d stb", c), stb3, (c % 2) == 1);
                checkOutput($sformatf("t2 c%0d trits", c), trits3, mt);
                for (int i = 0; i < 3; i++) begin
                    if (mt[2*i +: 2] != 2'd0) begin
                        checkOutput($sformatf("t2 c%0d pin%0d", c, i), pins3[i], mt[2*i +: 2] == 2'd2);
                    end
                end
                if (stb3) stbCnt++;
                busyCnt++;
                lastTrits = trits3;
                if (c == 8 && !pulsed) begin
                    s = 1'b1;
                    pulsed = 1'b1;
                end
                c++;
            end else if (done3) begin
                doneCnt++;
                checkOutput("t2 trits at done", trits3, 6'b101010);
                s = 1'b1;
            end else begin
                finished = 1'b1;
            end
            if (!finished) applyStimulus(s, 1'b0, 1'b0);
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL t2 timeout: sweep still running, busy=%0d", busy3);
        end
        checkOutput("t2 busy cycles", busyCnt, 54);
        checkOutput("t2 stb pulses", stbCnt, 27);
        checkOutput("t2 done pulses", doneCnt, 1);
        checkOutput("t2 final trits", lastTrits, 6'b101010);
        checkOutput("t6 start in DONE ignored", busy3, 0);

        // start and abort together in IDLE: abort wins, nothing is cleared
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t6 start+abort busy", busy3, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6 idle busy", busy3, 0);
        checkOutput("t6 idle vec_idx", vidx3, 26);

        // Loop mode: wrap with done pulse while busy stays high, then abort at vector 5
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitIdx3(26, 1'b1, 80, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3 wrap vec_idx", vidx3, 0);
        checkOutput("t3 wrap done", done3, 1);
        checkOutput("t3 wrap busy", busy3, 1);
        checkOutput("t3 wrap trits", trits3, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t3 after wrap done", done3, 0);
        checkOutput("t3 after wrap busy", busy3, 1);
        waitIdx3(5, 1'b0, 30, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t3 abort busy", busy3, 0);
        checkOutput("t3 abort done", done3, 0);
        checkOutput("t3 abort stb", stb3, 0);
        checkOutput("t3 abort obs kept", obs3, 6'b100000);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t3 abort no late done", done3, 0);
        checkOutput("t3 abort stays idle", busy3, 0);

        // Asynchronous reset mid-sweep, then restart from vector 0
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitIdx3(10, 1'b0, 40, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 async busy", busy3, 0);
        checkOutput("t5 async done", done3, 0);
        checkOutput("t5 async stb", stb3, 0);
        checkOutput("t5 async vec_idx", vidx3, 0);
        checkOutput("t5 async trits", trits3, 0);
        checkOutput("t5 async obs", obs3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t5 restart busy", busy3, 1);
        checkOutput("t5 restart vec_idx", vidx3, 0);
        checkOutput("t5 restart trits", trits3, 0);
        checkOutput("t5 restart stb", stb3, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 restart stb dwell1", stb3, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5 restart vec_idx1", vidx3, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5 final abort busy", busy3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
